pipeline_fetch_unit: RTL and testbench

//  Instruction-fetch (IF) stage of the pipelined ARM core; the requester side of pipeline_instruction_memory.

---
 rtl/pipeline_fetch_unit_pkg.sv | 20 ++
 rtl/pipeline_fetch_unit_if.sv | 12 +
 rtl/pipeline_fetch_unit_pc_register.sv | 24 ++
 rtl/pipeline_fetch_unit.sv | 118 +++++++++++
 tb/tb_pipeline_fetch_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_fetch_unit_pkg.sv
// Shared constants, state encoding and small helpers for the instruction-fetch stage.
package pipeline_fetch_unit_pkg;

  localparam int INSTR_BYTES = 4;

  typedef logic [31:0] instr_t;

  localparam instr_t BUBBLE_INSTR = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  // Instructions are word-sized, so only the two low address bits matter.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/pipeline_fetch_unit_if.sv
// Request/response bus between the fetch stage and the combinational instruction memory.
interface pipeline_fetch_unit_if
  import pipeline_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] read_address;
  instr_t                instruction;

  modport master (output read_address, input instruction);
  modport slave  (input read_address, output instruction);
endinterface

// File: rtl/pipeline_fetch_unit_pc_register.sv
// Program-counter register: async reset to RESET_PC, loads next_pc when load is high.
module pipeline_pc_register #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  output logic [ADDR_WIDTH-1:0] pc
);

  // PC state; holds unless the fetch logic requests a load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= next_pc;
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/pipeline_fetch_unit.sv
// IF stage: owns the PC, drives the instruction memory address and registers the
// returned word into IF/ID, handling stall, redirect, range/alignment faults and halt.
module pipeline_fetch_unit
  import pipeline_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    MEM_BYTES    = 128,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
  parameter bit                    HALT_ON_ZERO = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  pipeline_fetch_unit_if.master  imem,
  output logic [ADDR_WIDTH-1:0]  if_id_pc,
  output instr_t                 if_id_instruction,
  output logic                   if_id_valid,
  output logic                   halted,
  output logic                   misaligned
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PC  = ADDR_WIDTH'(MEM_BYTES - INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(INSTR_BYTES);

  fetch_state_e          state_r;
  fetch_state_e          next_state_s;
  logic [ADDR_WIDTH-1:0] pc_s;
  logic [ADDR_WIDTH-1:0] pc_next_s;
  logic                  pc_load_s;
  logic [ADDR_WIDTH-1:0] if_id_pc_next_s;
  instr_t                if_id_instruction_next_s;
  logic                  if_id_valid_next_s;
  logic                  misaligned_next_s;

  pipeline_pc_register #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_register (
    .clk     (clk),
    .reset   (reset),
    .load    (pc_load_s),
    .next_pc (pc_next_s),
    .pc      (pc_s)
  );

  assign imem.read_address = pc_s;

  // Next-state and next IF/ID selection; redirect outranks stall, range check precedes fetch
  always_comb begin
    next_state_s             = state_r;
    pc_load_s                = 1'b0;
    pc_next_s                = pc_s;
    if_id_pc_next_s          = if_id_pc;
    if_id_instruction_next_s = if_id_instruction;
    if_id_valid_next_s       = if_id_valid;
    misaligned_next_s        = misaligned;
    case (state_r)
      FETCH: begin
        if (branch_taken) begin
          if_id_valid_next_s       = 1'b0;
          if_id_instruction_next_s = BUBBLE_INSTR;
          if (!is_word_aligned(branch_target[1:0])) begin
            misaligned_next_s = 1'b1;
            next_state_s      = HALT;
          end else if (branch_target > LAST_PC) begin
            next_state_s = HALT;
          end else begin
            pc_load_s = 1'b1;
            pc_next_s = branch_target;
          end
        end else if (stall) begin
          pc_load_s = 1'b0;
        end else if (pc_s > LAST_PC) begin
          if_id_valid_next_s = 1'b0;
          next_state_s       = HALT;
        end else if (HALT_ON_ZERO && (imem.instruction == BUBBLE_INSTR)) begin
          if_id_valid_next_s = 1'b0;
          next_state_s       = HALT;
        end else begin
          if_id_pc_next_s          = pc_s;
          if_id_instruction_next_s = imem.instruction;
          if_id_valid_next_s       = 1'b1;
          pc_load_s                = 1'b1;
          pc_next_s                = pc_s + PC_STEP;
        end
      end
      HALT: begin
        if_id_valid_next_s = 1'b0;
      end
      default: begin
        if_id_valid_next_s = 1'b0;
        next_state_s       = HALT;
      end
    endcase
  end

  // State, IF/ID pipeline register and sticky status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r           <= FETCH;
      if_id_pc          <= '0;
      if_id_instruction <= BUBBLE_INSTR;
      if_id_valid       <= 1'b0;
      halted            <= 1'b0;
      misaligned        <= 1'b0;
    end else begin
      state_r           <= next_state_s;
      if_id_pc          <= if_id_pc_next_s;
      if_id_instruction <= if_id_instruction_next_s;
      if_id_valid       <= if_id_valid_next_s;
      halted            <= (next_state_s == HALT);
      misaligned        <= misaligned_next_s;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Directed bench for pipeline_fetch_unit: one instance without and one with halt-on-zero,
// each fed by a byte-addressed little-endian memory model.
module tb_pipeline_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;

  logic [63:0] d0_if_id_pc, d1_if_id_pc;
  logic [31:0] d0_if_id_instruction, d1_if_id_instruction;
  logic        d0_if_id_valid, d1_if_id_valid;
  logic        d0_halted, d1_halted;
  logic        d0_misaligned, d1_misaligned;

  logic [7:0]  mem0 [0:127];
  logic [7:0]  mem1 [0:127];
  int          a0, a1;
  int          checks = 0;
  int          errors = 0;

  pipeline_fetch_unit_if #(.ADDR_WIDTH(64)) if0 ();
  pipeline_fetch_unit_if #(.ADDR_WIDTH(64)) if1 ();

  pipeline_fetch_unit #(.ADDR_WIDTH(64), .MEM_BYTES(128), .RESET_PC(64'h0), .HALT_ON_ZERO(1'b0)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(if0), .if_id_pc(d0_if_id_pc),
    .if_id_instruction(d0_if_id_instruction), .if_id_valid(d0_if_id_valid),
    .halted(d0_halted), .misaligned(d0_misaligned)
  );

  pipeline_fetch_unit #(.ADDR_WIDTH(64), .MEM_BYTES(128), .RESET_PC(64'h0), .HALT_ON_ZERO(1'b1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(if1), .if_id_pc(d1_if_id_pc),
    .if_id_instruction(d1_if_id_instruction), .if_id_valid(d1_if_id_valid),
    .halted(d1_halted), .misaligned(d1_misaligned)
  );

  always #5 clk = ~clk;

  // Little-endian, combinational memory models; out-of-range reads return zero
  always_comb begin
    a0 = int'(if0.read_address[6:0]);
    if0.instruction = 32'h0;
    if (if0.read_address < 64'd125)
      if0.instruction = {mem0[a0+3], mem0[a0+2], mem0[a0+1], mem0[a0]};
  end

  always_comb begin
    a1 = int'(if1.read_address[6:0]);
    if1.instruction = 32'h0;
    if (if1.read_address < 64'd125)
      if1.instruction = {mem1[a1+3], mem1[a1+2], mem1[a1+1], mem1[a1]};
  end

  task automatic write_word(input int which, input int addr, input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      if (which == 0) mem0[addr+b] = w[8*b +: 8];
      else            mem1[addr+b] = w[8*b +: 8];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 64'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (if0.read_address !== 64'h0) begin errors++; $display("FAIL reset_read_address: got %h expected %h", if0.read_address, 64'h0); end
    checks++; if (d0_if_id_pc !== 64'h0) begin errors++; $display("FAIL reset_if_id_pc: got %h expected %h", d0_if_id_pc, 64'h0); end
    checks++; if (d0_if_id_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", d0_if_id_instruction, 32'h0); end
    checks++; if (d0_if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", d0_if_id_valid); end
    checks++; if (d0_halted !== 1'b0 || d0_misaligned !== 1'b0) begin errors++; $display("FAIL reset_flags: got halted=%b misaligned=%b expected 0/0", d0_halted, d0_misaligned); end
    do_reset();
  endtask

  task automatic test_seq_fetch();
    step();
    checks++; if (d0_if_id_pc !== 64'h0) begin errors++; $display("FAIL seq1_pc: got %h expected %h", d0_if_id_pc, 64'h0); end
    checks++; if (d0_if_id_instruction !== 32'h8B1F03E5) begin errors++; $display("FAIL seq1_instr: got %h expected %h", d0_if_id_instruction, 32'h8B1F03E5); end
    checks++; if (d0_if_id_valid !== 1'b1) begin errors++; $display("FAIL seq1_valid: got %b expected 1", d0_if_id_valid); end
    checks++; if (if0.read_address !== 64'h4) begin errors++; $display("FAIL seq1_addr: got %h expected %h", if0.read_address, 64'h4); end
    step();
    checks++; if (d0_if_id_pc !== 64'h4) begin errors++; $display("FAIL seq2_pc: got %h expected %h", d0_if_id_pc, 64'h4); end
    checks++; if (d0_if_id_instruction !== 32'h11111111) begin errors++; $display("FAIL seq2_instr: got %h expected %h", d0_if_id_instruction, 32'h11111111); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (if0.read_address !== 64'h8) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected %h", i, if0.read_address, 64'h8); end
      checks++; if (d0_if_id_pc !== 64'h4 || d0_if_id_instruction !== 32'h11111111 || d0_if_id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_ifid[%0d]: got pc=%h instr=%h valid=%b expected pc=4 instr=11111111 valid=1", i, d0_if_id_pc, d0_if_id_instruction, d0_if_id_valid);
      end
    end
    stall = 1'b0;
    step();
    checks++; if (d0_if_id_pc !== 64'h8 || d0_if_id_instruction !== 32'h22222222) begin errors++; $display("FAIL stall_release: got pc=%h instr=%h expected pc=8 instr=22222222", d0_if_id_pc, d0_if_id_instruction); end
  endtask

  task automatic test_branch_over_stall();
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 64'h20;
    step();
    stall = 1'b0;
    branch_taken = 1'b0;
    checks++; if (d0_if_id_valid !== 1'b0 || d0_if_id_instruction !== 32'h0) begin errors++; $display("FAIL branch_bubble: got valid=%b instr=%h expected 0/0", d0_if_id_valid, d0_if_id_instruction); end
    checks++; if (if0.read_address !== 64'h20) begin errors++; $display("FAIL branch_pc: got %h expected %h", if0.read_address, 64'h20); end
    step();
    checks++; if (d0_if_id_pc !== 64'h20 || d0_if_id_instruction !== 32'h8B040086 || d0_if_id_valid !== 1'b1) begin
      errors++; $display("FAIL branch_fetch: got pc=%h instr=%h valid=%b expected pc=20 instr=8B040086 valid=1", d0_if_id_pc, d0_if_id_instruction, d0_if_id_valid);
    end
  endtask

  task automatic test_halt_on_zero();
    do_reset();
    step();
    checks++; if (d1_if_id_valid !== 1'b1 || d1_if_id_instruction !== 32'hAAAAAAAA) begin errors++; $display("FAIL hoz_first: got valid=%b instr=%h expected 1/AAAAAAAA", d1_if_id_valid, d1_if_id_instruction); end
    step();
    checks++; if (d1_if_id_valid !== 1'b0 || d1_halted !== 1'b1) begin errors++; $display("FAIL hoz_halt: got valid=%b halted=%b expected 0/1", d1_if_id_valid, d1_halted); end
    branch_taken = 1'b1;
    branch_target = 64'h10;
    step();
    step();
    branch_taken = 1'b0;
    checks++; if (if1.read_address !== 64'h4) begin errors++; $display("FAIL hoz_branch_ignored: got %h expected %h", if1.read_address, 64'h4); end
    checks++; if (d1_halted !== 1'b1 || d1_if_id_valid !== 1'b0) begin errors++; $display("FAIL hoz_stay: got halted=%b valid=%b expected 1/0", d1_halted, d1_if_id_valid); end
  endtask

  task automatic test_bad_target();
    do_reset();
    step();
    branch_taken = 1'b1;
    branch_target = 64'h22;
    step();
    branch_taken = 1'b0;
    checks++; if (d0_misaligned !== 1'b1 || d0_halted !== 1'b1 || d0_if_id_valid !== 1'b0) begin
      errors++; $display("FAIL misaligned: got mis=%b halted=%b valid=%b expected 1/1/0", d0_misaligned, d0_halted, d0_if_id_valid);
    end
    checks++; if (if0.read_address !== 64'h4) begin errors++; $display("FAIL misaligned_pc: got %h expected %h", if0.read_address, 64'h4); end
    do_reset();
    branch_taken = 1'b1;
    branch_target = 64'h80;
    step();
    branch_taken = 1'b0;
    checks++; if (d0_halted !== 1'b1 || d0_misaligned !== 1'b0 || d0_if_id_valid !== 1'b0) begin
      errors++; $display("FAIL out_of_range: got halted=%b mis=%b valid=%b expected 1/0/0", d0_halted, d0_misaligned, d0_if_id_valid);
    end
  endtask

  task automatic test_end_of_memory();
    do_reset();
    for (int i = 0; i < 31; i++) step();
    checks++; if (if0.read_address !== 64'h7C || d0_halted !== 1'b0) begin errors++; $display("FAIL eom_reach: got addr=%h halted=%b expected 7C/0", if0.read_address, d0_halted); end
    step();
    checks++; if (d0_if_id_pc !== 64'h7C || d0_if_id_instruction !== 32'hCAFEF00D || d0_if_id_valid !== 1'b1) begin
      errors++; $display("FAIL eom_last: got pc=%h instr=%h valid=%b expected 7C/CAFEF00D/1", d0_if_id_pc, d0_if_id_instruction, d0_if_id_valid);
    end
    step();
    checks++; if (d0_if_id_valid !== 1'b0 || d0_halted !== 1'b1) begin errors++; $display("FAIL eom_halt: got valid=%b halted=%b expected 0/1", d0_if_id_valid, d0_halted); end
    #2 reset = 1'b1;
    #1;
    checks++; if (if0.read_address !== 64'h0 || d0_if_id_pc !== 64'h0 || d0_if_id_instruction !== 32'h0) begin
      errors++; $display("FAIL async_reset_regs: got addr=%h pc=%h instr=%h expected 0/0/0", if0.read_address, d0_if_id_pc, d0_if_id_instruction);
    end
    checks++; if (d0_if_id_valid !== 1'b0 || d0_halted !== 1'b0 || d0_misaligned !== 1'b0) begin
      errors++; $display("FAIL async_reset_flags: got valid=%b halted=%b mis=%b expected 0/0/0", d0_if_id_valid, d0_halted, d0_misaligned);
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    write_word(0, 32'h00, 32'h8B1F03E5);
    write_word(0, 32'h04, 32'h11111111);
    write_word(0, 32'h08, 32'h22222222);
    write_word(0, 32'h0C, 32'h33333333);
    write_word(0, 32'h20, 32'h8B040086);
    write_word(0, 32'h7C, 32'hCAFEF00D);
    write_word(1, 32'h00, 32'hAAAAAAAA);
    write_word(1, 32'h10, 32'h55555555);

    test_reset();
    test_seq_fetch();
    test_stall();
    test_branch_over_stall();
    test_halt_on_zero();
    test_bad_target();
    test_end_of_memory();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
